karatsuba_mul_seq: RTL



---
 rtl/karatsuba_mul_seq_pkg.sv | 23 ++
 rtl/karatsuba_mul_4.sv | 27 ++
 rtl/karatsuba_mul_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/karatsuba_mul_seq_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: digit width,
// controller state encoding and the digit counter sizing helper.
package karatsuba_mul_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(d)), never below 1 so a counter always has at least one bit.
  function automatic int cnt_width(input int d);
    int w;
    w = 1;
    while ((1 << w) < d) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/karatsuba_mul_4.sv
// 4x4 unsigned Karatsuba multiplier: splits each operand into 2-bit halves
// and forms the product from three 2/3-bit multiplications.
module karatsuba_mul_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] z2;
  logic [3:0] z0;
  logic [2:0] sum_a;
  logic [2:0] sum_b;
  logic [5:0] z1_full;
  logic [5:0] z1;

  // Middle term (ah+al)(bh+bl) - z2 - z0 equals ah*bl + al*bh, at most 18.
  always_comb begin
    z2      = {2'b00, a[3:2]} * {2'b00, b[3:2]};
    z0      = {2'b00, a[1:0]} * {2'b00, b[1:0]};
    sum_a   = {1'b0, a[3:2]} + {1'b0, a[1:0]};
    sum_b   = {1'b0, b[3:2]} + {1'b0, b[1:0]};
    z1_full = {3'b000, sum_a} * {3'b000, sum_b};
    z1      = z1_full - {2'b00, z2} - {2'b00, z0};
    p       = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
  end

endmodule

// File: rtl/karatsuba_mul_seq.sv
// Multi-cycle N x N unsigned multiplier. One shared 4x4 core is fed one digit
// pair per cycle; shifted partial products are summed in a 2N-bit accumulator.
//
// Handshake: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; a product transfers on a rising edge where out_valid
// and out_ready are both high. out_valid/p stay stable until that transfer,
// and in_valid is ignored whenever in_ready is low.
module karatsuba_mul_seq
  import karatsuba_mul_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int D  = N / DIGIT_W;
  localparam int CW = cnt_width(D);
  // Shift amount reaches 4*(2D-2) < 8D <= 2^(CW+3).
  localparam int SW = CW + 3;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_e           state_q;
  state_e           state_d;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2*N-1:0]   acc_q;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    j_q;

  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [7:0]         prod;
  logic [SW-1:0]      shamt;
  logic [2*N-1:0]     term;
  logic               last_pair;

  // Digit selection and alignment of the current partial product.
  always_comb begin
    dig_a     = DIGIT_W'(a_q >> {i_q, 2'b00});
    dig_b     = DIGIT_W'(b_q >> {j_q, 2'b00});
    shamt     = (SW'(i_q) + SW'(j_q)) << 2;
    term      = {{(2*N-8){1'b0}}, prod} << shamt;
    last_pair = (i_q == LAST) && (j_q == LAST);
  end

  karatsuba_mul_4 u_core (
    .a (dig_a),
    .b (dig_b),
    .p (prod)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_pair) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, digit counters and partial-product accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_q + term;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p = acc_q;

endmodule
